// File: rtl/sel_commit_pkg.sv
// Shared types and constants for the select-commit mux and its stabilizer.
// Lane count, counter ceiling and the stability-counter width helper live here.
package sel_commit_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam int LANES = 8;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic int stab_w(input int stable_cyc);
    return $clog2(stable_cyc + 1);
  endfunction

endpackage

// File: rtl/sel_stabilizer.sv
// Debounces the upstream select code and pulses commit when a new value has held
// for STABLE_CYC consecutive edges and differs from the currently active select.
//
//   state  | meaning
//   IDLE   | cand equals sel_active, nothing pending
//   SETTLE | counting consecutive edges on which selsw matched cand
module sel_stabilizer
  import sel_commit_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] selsw,
  output logic [2:0] sel_active,
  output logic [2:0] cand,
  output logic       commit
);

  localparam int SW = stab_w(STABLE_CYC);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);

  state_t        state;
  logic [SW-1:0] stab;
  logic          settled;

  assign settled = (state == SETTLE) && (selsw == cand) && (stab == STAB_LAST);
  // Combinational so the parent can capture the lane on the same edge sel_active moves.
  assign commit  = settled && (cand != sel_active) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cand       <= 3'd0;
      stab       <= '0;
      sel_active <= 3'd0;
    end else if (selsw != cand) begin
      cand  <= selsw;
      stab  <= STAB_ONE;
      state <= SETTLE;
    end else if (state == SETTLE) begin
      if (stab == STAB_LAST) begin
        state <= IDLE;
        if (cand != sel_active) sel_active <= cand;
      end else begin
        stab <= stab + STAB_ONE;
      end
    end
  end

endmodule

// File: rtl/sel_commit_mux.sv
// Commits a debounced select, captures the chosen lane into a single-entry
// valid/ready register, counts commits and flags overwritten unconsumed data.
module sel_commit_mux
  import sel_commit_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              selsw,
  input  logic [LANES*DATA_W-1:0] din_flat,
  input  logic                    dout_ready,
  output logic [DATA_W-1:0]       dout,
  output logic                    dout_valid,
  output logic [2:0]              sel_active,
  output logic [7:0]              change_cnt,
  output logic                    overrun
);

  logic [2:0]        cand;
  logic              commit;
  logic [DATA_W-1:0] lanes [LANES];
  logic [DATA_W-1:0] sel_lane;
  logic              transfer;

  sel_stabilizer #(
    .STABLE_CYC (STABLE_CYC)
  ) u_stab (
    .clk        (clk),
    .reset      (reset),
    .selsw      (selsw),
    .sel_active (sel_active),
    .cand       (cand),
    .commit     (commit)
  );

  always_comb begin
    for (int i = 0; i < LANES; i++) lanes[i] = din_flat[i*DATA_W +: DATA_W];
  end

  assign sel_lane = lanes[cand];
  assign transfer = dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      change_cnt <= 8'd0;
      overrun    <= 1'b0;
    end else if (commit) begin
      // Latest wins; only flag loss when the pending value was not taken this edge.
      dout       <= sel_lane;
      dout_valid <= 1'b1;
      if (change_cnt != CNT_MAX) change_cnt <= change_cnt + 8'd1;
      if (dout_valid && !dout_ready) overrun <= 1'b1;
    end else if (transfer) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sel_commit_mux.sv
// Directed bench for sel_commit_mux: expected transfers are queued by the stimulus
// and checked by a negedge monitor whenever the DUT hands off data.
module tb_sel_commit_mux;

  localparam int DW = 8;
  localparam int SC = 4;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] cnt;
    logic       ovr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    selsw;
  logic [63:0]   din_flat;
  logic          dout_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [2:0]    sel_active;
  logic [7:0]    change_cnt;
  logic          overrun;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];

  sel_commit_mux #(.DATA_W(DW), .STABLE_CYC(SC)) dut (
    .clk        (clk),
    .reset      (reset),
    .selsw      (selsw),
    .din_flat   (din_flat),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sel_active (sel_active),
    .change_cnt (change_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset(input logic [2:0] sel);
    reset      = 1'b1;
    selsw      = sel;
    dout_ready = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic set_default_lanes();
    for (int i = 0; i < 8; i++) din_flat[i*8 +: 8] = 8'h10 + 8'(i);
  endtask

  function automatic logic [7:0] lane_of(input logic [63:0] d, input int i);
    return d[i*8 +: 8];
  endfunction

  function automatic exp_t mk(input logic [2:0] s, input logic [7:0] d,
                              input logic [7:0] c, input logic o);
    exp_t e;
    e.sel = s; e.d = d; e.cnt = c; e.ovr = o;
    return e;
  endfunction

  // Monitor: every handshake transfer must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected actual sel=%0d dout=%0h cnt=%0d ovr=%0b required none",
                 sel_active, dout, change_cnt, overrun);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if ({sel_active, dout, change_cnt, overrun} !== e) begin
          errors++;
          $display("FAIL xfer actual sel=%0d dout=%0h cnt=%0d ovr=%0b required sel=%0d dout=%0h cnt=%0d ovr=%0b",
                   sel_active, dout, change_cnt, overrun, e.sel, e.d, e.cnt, e.ovr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] prev, committed, v;
    logic [7:0] cnt;
    int         hold;

    reset = 1'b1; selsw = 3'd0; dout_ready = 1'b0; din_flat = '0;
    set_default_lanes();

    // Reset with a non-zero select already present.
    do_reset(3'd5);
    reset = 1'b1;
    chk("rst_sel", 32'(sel_active), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_cnt", 32'(change_cnt), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick(3);
    chk("rst_nocommit_early", 32'(sel_active), 32'd0);
    tick(1);
    chk("rst_commit_sel", 32'(sel_active), 32'd5);
    chk("rst_commit_dout", 32'(dout), 32'h15);
    expq.push_back(mk(3'd5, 8'h15, 8'd1, 1'b0));
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    chk("rst_drain_valid", 32'(dout_valid), 32'd0);

    // Clean change 0 -> 3.
    do_reset(3'd0);
    selsw = 3'd3;
    tick(3);
    chk("clean_pre_sel", 32'(sel_active), 32'd0);
    tick(1);
    chk("clean_sel", 32'(sel_active), 32'd3);
    chk("clean_dout", 32'(dout), 32'h13);
    chk("clean_valid", 32'(dout_valid), 32'd1);
    chk("clean_cnt", 32'(change_cnt), 32'd1);
    expq.push_back(mk(3'd3, 8'h13, 8'd1, 1'b0));
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    chk("clean_xfer_valid", 32'(dout_valid), 32'd0);
    chk("clean_xfer_dout", 32'(dout), 32'h13);
    din_flat = {8{8'hA5}};
    tick(2);
    chk("clean_din_ignored", 32'(dout), 32'h13);
    set_default_lanes();

    // Glitch rejection: short excursion then restart on a second change.
    do_reset(3'd0);
    selsw = 3'd6;
    tick(2);
    selsw = 3'd0;
    tick(6);
    chk("glitch_cnt", 32'(change_cnt), 32'd0);
    chk("glitch_valid", 32'(dout_valid), 32'd0);
    chk("glitch_sel", 32'(sel_active), 32'd0);
    selsw = 3'd6;
    tick(2);
    selsw = 3'd2;
    tick(3);
    chk("glitch_restart_pre", 32'(sel_active), 32'd0);
    tick(1);
    chk("glitch_restart_sel", 32'(sel_active), 32'd2);
    chk("glitch_restart_dout", 32'(dout), 32'h12);
    chk("glitch_restart_cnt", 32'(change_cnt), 32'd1);
    expq.push_back(mk(3'd2, 8'h12, 8'd1, 1'b0));
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;

    // Overrun: second commit lands on an unconsumed value.
    do_reset(3'd0);
    selsw = 3'd1;
    tick(4);
    chk("ovr_first_dout", 32'(dout), 32'h11);
    chk("ovr_first_flag", 32'(overrun), 32'd0);
    selsw = 3'd7;
    tick(4);
    chk("ovr_dout", 32'(dout), 32'h17);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_cnt", 32'(change_cnt), 32'd2);
    expq.push_back(mk(3'd7, 8'h17, 8'd2, 1'b1));
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    chk("ovr_drain_valid", 32'(dout_valid), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Simultaneous commit and transfer.
    do_reset(3'd0);
    selsw = 3'd2;
    tick(4);
    selsw = 3'd4;
    tick(3);
    dout_ready = 1'b1;
    expq.push_back(mk(3'd2, 8'h12, 8'd1, 1'b0));
    tick(1);
    chk("simul_dout", 32'(dout), 32'h14);
    chk("simul_valid", 32'(dout_valid), 32'd1);
    chk("simul_ovr", 32'(overrun), 32'd0);
    chk("simul_cnt", 32'(change_cnt), 32'd2);
    expq.push_back(mk(3'd4, 8'h14, 8'd2, 1'b0));
    tick(1);
    dout_ready = 1'b0;
    chk("simul_drain_valid", 32'(dout_valid), 32'd0);

    // Random upstream select runs with random lane data every cycle.
    do_reset(3'd0);
    dout_ready = 1'b1;
    prev = 3'd0; committed = 3'd0; cnt = 8'd0;
    for (int r = 0; r < 60; r++) begin
      v    = 3'((32'(prev) + $urandom_range(1, 7)) % 8);
      hold = int'($urandom_range(1, 7));
      selsw = v;
      for (int h = 0; h < hold; h++) begin
        din_flat = {$urandom, $urandom};
        if (h == SC - 1 && v != committed) begin
          committed = v;
          cnt       = cnt + 8'd1;
          expq.push_back(mk(v, lane_of(din_flat, int'(v)), cnt, 1'b0));
        end
        tick(1);
      end
      prev = v;
    end
    tick(2);
    chk("rand_cnt", 32'(change_cnt), 32'(cnt));
    chk("rand_queue_empty", 32'(expq.size()), 32'd0);

    // Saturation: 260 alternating commits.
    do_reset(3'd0);
    set_default_lanes();
    dout_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      v = (k % 2 == 1) ? 3'd2 : 3'd1;
      selsw = v;
      tick(4);
      expq.push_back(mk(v, 8'h10 + 8'(v), (k + 1 > 255) ? 8'd255 : 8'(k + 1), 1'b0));
    end
    tick(2);
    dout_ready = 1'b0;
    chk("sat_cnt", 32'(change_cnt), 32'd255);
    chk("sat_queue_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sel_commit_mux.md
Name: sel_commit_mux

Overview:
- Downstream consumer of the 3-bit switch-select code produced by the serial pattern-detector FSM (input `x`, output `selsw[2:0]`).
- Debounces `selsw` and commits a new selection only after it has held stable for a programmable number of cycles.
- On each commit, captures the selected one of eight data lanes and presents it on a single-entry valid/ready output register.
- Counts committed selection changes.

Parameters:
- DATA_W, 8, width of each data lane and of `dout`.
- STABLE_CYC, 4, consecutive sampling edges `selsw` must hold before commit (legal range 2..15).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- selsw  in  3  select code from the upstream detector FSM.
- din_flat  in  8*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- dout_ready  in  1  downstream accepts `dout` this cycle.
- dout  out  DATA_W  captured lane data.
- dout_valid  out  1  `dout` holds an unconsumed value.
- sel_active  out  3  currently committed select.
- change_cnt  out  8  number of commits, saturating.
- overrun  out  1  sticky; a pending output was overwritten before acceptance.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - Outputs: `sel_active`=0, `dout`=0, `dout_valid`=0, `change_cnt`=0, `overrun`=0.
  - Internal: candidate `cand`=0, stability counter `stab`=0, state=IDLE.
  - No commit occurs on the reset edge.
  - Reset mid-SETTLE discards the candidate.
- FSM states:
  - IDLE: `cand`==`sel_active`, nothing pending.
  - SETTLE: counting stability of `cand`.
- Every edge, state-independent: if `selsw`!=`cand`, then `cand`<=`selsw`, `stab`<=1, state<=SETTLE.
  - This applies in SETTLE too: a glitch restarts the count with the new value.
- SETTLE, `selsw`==`cand`, `stab`<STABLE_CYC-1: `stab`<=`stab`+1.
- SETTLE, `selsw`==`cand`, `stab`==STABLE_CYC-1:
  - If `cand`!=`sel_active`, commit. Otherwise return to IDLE with no commit, no count and no output.
  - Either way, state<=IDLE.
- Latency: new `selsw` value first sampled at edge E0, held through edge E0+STABLE_CYC-1 → commit on edge E0+STABLE_CYC-1. Results are visible in the following cycle.
- Commit actions, all on the same edge:
  - `sel_active`<=`cand`.
  - `dout`<=lane[`cand`], sampled from `din_flat` at that edge.
  - `dout_valid`<=1.
  - `change_cnt`<=`change_cnt`+1, saturating at 255 (no wrap).
- Output handshake:
  - Transfer occurs on an edge where `dout_valid`&&`dout_ready`.
  - With no simultaneous commit, a transfer clears `dout_valid`.
  - `dout` holds its value while `dout_valid`=0; it is not re-sampled.
- Simultaneous commit and transfer: old value is consumed, new value is loaded, `dout_valid` stays 1, `overrun` is unchanged.
- Commit while `dout_valid`=1 and `dout_ready`=0: new value overwrites (latest wins) and `overrun`<=1. `overrun` is cleared only by reset.
- `dout_ready` while `dout_valid`=0: ignored.
- `din_flat` changes outside commit edges have no effect on `dout`.

Decomposition:
- Shared package `sel_commit_pkg`:
  - state enum {IDLE, SETTLE}.
  - localparam LANES=8.
  - function `stab_w(STABLE_CYC)` = $clog2(STABLE_CYC+1).
  - localparam CNT_MAX=8'hFF.
- Natural sub-module `sel_stabilizer`:
  - Ports: clk, reset, selsw → `sel_active`, `commit` pulse.
  - Contains `cand`, `stab` and the FSM.
- Parent holds the lane mux, output register, handshake, counter and `overrun`.

Test Plan:
- Reset behaviour: assert reset 2 cycles with `selsw`=5 and `dout_ready`=0 → all outputs 0. After release, hold `selsw`=5 → commit 4 cycles later, `sel_active`=5.
- Clean change: lanes = 8'h10+i; `selsw` 0→3 at E0, `dout_ready`=0 → at E0+3 `sel_active`=3, `dout`=8'h13, `dout_valid`=1, `change_cnt`=1. Then `dout_ready`=1 for one edge → `dout_valid`=0 and `dout` stays 8'h13.
- Glitch rejection: `selsw` 0→6 for 2 edges then back to 0 → no commit, `change_cnt`=0, `dout_valid`=0. Also `selsw` 0→6→2 → `stab` restarts and only 2 commits, 4 edges after the 6→2 change.
- Overrun: commit select 1, keep `dout_ready`=0, commit select 7 → `dout`=lane7, `overrun`=1, `change_cnt`=2. Then `dout_ready`=1 → `dout_valid`=0 and `overrun` stays 1.
- Simultaneous: `dout_valid`=1 with select 2 pending; `dout_ready`=1 on the edge committing select 4 → `dout`=lane4, `dout_valid`=1, `overrun`=0.
- Saturation and random upstream:
  - 260 commits alternating 1/2 → `change_cnt`=255.
  - Random `x` to the upstream detector → `dout` always equals `din_flat` lane[`sel_active`] captured at the commit edge.
